// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO on the Ibex req/gnt/rvalid bus
module bus_uart_tx #(
  parameter int unsigned FifoDepth     = 8,
  parameter logic [15:0] DefaultClkDiv = 16'd433
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int unsigned AW = $clog2(FifoDepth);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FullLevel = LW'(FifoDepth);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  logic [7:0]    mem_q [FifoDepth];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   clkdiv_q, clkdiv_d, div_q, div_d, cnt_q, cnt_d;
  logic          en_q, en_d, irq_en_q, irq_en_d;
  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic          rvalid_q, rvalid_d, err_q, err_d;
  logic [31:0]   rdata_q, rdata_d, status;
  logic [1:0]    sel;
  logic          wr, rd, full, empty, busy, tick, start_ok, push_req, push, pop;
  logic          unused;
  assign unused   = ^{addr_i[31:4], addr_i[1:0], be_i[3:2], wdata_i[31:16]};
  assign sel      = addr_i[3:2];
  assign wr       = req_i & we_i;
  assign rd       = req_i & ~we_i;
  assign full     = level_q == FullLevel;
  assign empty    = level_q == '0;
  assign busy     = state_q != IDLE;
  assign tick     = cnt_q == '0;
  assign start_ok = en_q & ~empty;
  assign push_req = wr & (sel == 2'd0) & be_i[0];
  // a full FIFO rejects the push even when the transmitter pops in the same cycle
  assign push     = push_req & ~full;
  assign status   = {20'b0, 4'(level_q), 5'b0, busy, empty, full};
  assign gnt_o    = req_i;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign tx_o     = (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[0] : 1'b1;
  assign irq_o    = irq_en_q & empty & ~busy;
  always_comb begin
    rvalid_d = req_i;
    rdata_d  = !rd ? 32'b0 :
               (sel == 2'd1) ? status :
               (sel == 2'd2) ? {16'b0, clkdiv_q} :
               (sel == 2'd3) ? {30'b0, irq_en_q, en_q} : 32'b0;
    err_d    = wr & ((sel == 2'd1) | (push_req & full));
    clkdiv_d = {(wr & (sel == 2'd2) & be_i[1]) ? wdata_i[15:8] : clkdiv_q[15:8],
                (wr & (sel == 2'd2) & be_i[0]) ? wdata_i[7:0]  : clkdiv_q[7:0]};
    en_d     = (wr & (sel == 2'd3) & be_i[0]) ? wdata_i[0] : en_q;
    irq_en_d = (wr & (sel == 2'd3) & be_i[0]) ? wdata_i[1] : irq_en_q;
  end
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    div_d   = div_q;
    pop     = 1'b0;
    cnt_d   = busy ? (tick ? div_q : cnt_q - 16'd1) : cnt_q;
    unique case (state_q)
      IDLE:  if (start_ok) begin
        pop     = 1'b1;
        state_d = START;
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = 3'd0;
      end
      DATA:  if (tick) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      STOP:  if (tick) begin
        pop     = start_ok;
        state_d = start_ok ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // every frame latches the bit time in force when it starts
    if (pop) begin
      shift_d = mem_q[rptr_q];
      div_d   = clkdiv_q;
      cnt_d   = clkdiv_q;
    end
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    level_d = level_q + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wdata_i[7:0];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      clkdiv_q <= DefaultClkDiv;
      div_q    <= DefaultClkDiv;
      cnt_q    <= '0;
      en_q     <= 1'b1;
      irq_en_q <= 1'b0;
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      clkdiv_q <= clkdiv_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule

// File: tb/tb_bus_uart_tx.sv
// tb_bus_uart_tx: scoreboard bench; bus responses and serial frames are queued at issue and checked by monitors
module tb_bus_uart_tx;
  logic        clk_i = 1'b0, rst_ni = 1'b0, req_i = 1'b0, we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic        gnt_o, rvalid_o, err_o, tx_o, irq_o;
  logic [31:0] rdata_o;
  typedef struct {logic [31:0] rd; logic err; int due;} resp_t;
  typedef struct {logic [7:0] data; int div;} frame_t;
  resp_t  bq[$];
  frame_t exp_q[$];
  int     starts[$];
  int     cyc = 0, checks = 0, errors = 0, frames_exp = 0, frames_done = 0, t0;
  bus_uart_tx #(.FifoDepth(8), .DefaultClkDiv(16'd433)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .tx_o(tx_o), .irq_o(irq_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic bus(input logic we, input logic [3:0] off, input logic [31:0] data, input logic [3:0] be,
                     input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; addr_i = {28'h0, off}; wdata_i = data; be_i = be;
    bq.push_back('{exp_rd, exp_err, cyc + 1});
    #1 check("gnt", gnt_o, 1);
    @(posedge clk_i);
    #1 req_i = 1'b0; we_i = 1'b0;
  endtask
  task automatic txb(input logic [7:0] d, input int div, input bit counted);
    bus(1'b1, 4'h0, {24'h0, d}, 4'hF, 32'h0, 1'b0);
    exp_q.push_back('{d, div});
    if (counted) frames_exp++;
  endtask
  task automatic wait_frames(input int limit);
    int n = 0;
    while (frames_done < frames_exp && n < limit) begin
      @(negedge clk_i);
      n++;
    end
    check("frames_done", frames_done, frames_exp);
  endtask
  always @(negedge clk_i) begin
    resp_t r;
    if (rvalid_o) begin
      if (bq.size() == 0) check("bus_spurious_rvalid", 1, 0);
      else begin
        r = bq.pop_front();
        check("bus_resp", {31'b0, err_o, rdata_o}, {31'b0, r.err, r.rd});
        check("bus_latency", cyc, r.due);
      end
    end
  end
  initial begin : tx_mon
    frame_t f;
    logic bad, ab, eb;
    logic [7:0] obs;
    forever begin
      @(negedge clk_i);
      if (rst_ni && tx_o === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("tx_unexpected_frame", 1, 0);
          wait (tx_o === 1'b1);
        end else begin
          f = exp_q.pop_front();
          starts.push_back(cyc);
          bad = 1'b0; ab = 1'b0; obs = '0;
          for (int b = 0; b < 10 && !ab; b++)
            for (int c = 0; c <= f.div && !ab; c++) begin
              if (b != 0 || c != 0) @(negedge clk_i);
              if (!rst_ni) ab = 1'b1;
              else begin
                eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : f.data[b-1];
                if (tx_o !== eb) bad = 1'b1;
                if (c == f.div && b > 0 && b < 9) obs[b-1] = tx_o;
              end
            end
          if (!ab) begin
            check("tx_frame", {55'b0, bad, obs}, {55'b0, 1'b0, f.data});
            frames_done++;
          end
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
  initial begin
    int n;
    logic [7:0] fill [9] = '{8'h3C, 8'h00, 8'hFF, 8'h81, 8'h5A, 8'h7E, 8'h12, 8'hC3, 8'h99};
    repeat (3) @(negedge clk_i);
    check("rst_tx", tx_o, 1);
    check("rst_irq", irq_o, 0);
    check("rst_rvalid", {rvalid_o, err_o, rdata_o}, 0);
    rst_ni = 1'b1;
    bus(1'b0, 4'h4, 0, 4'hF, 32'h0000_0002, 1'b0);
    bus(1'b0, 4'h8, 0, 4'hF, 32'h0000_01B1, 1'b0);
    bus(1'b0, 4'hC, 0, 4'hF, 32'h0000_0001, 1'b0);
    bus(1'b0, 4'h0, 0, 4'hF, 32'h0000_0000, 1'b0);
    check("idle_tx", tx_o, 1);
    // single frame 0xA5 at CLKDIV=3; status before and after the pop
    bus(1'b1, 4'h8, 32'h3, 4'hF, 0, 1'b0);
    starts.delete();
    txb(8'hA5, 3, 1'b1);
    t0 = cyc;
    bus(1'b0, 4'h4, 0, 4'hF, 32'h0000_0100, 1'b0);
    bus(1'b0, 4'h4, 0, 4'hF, 32'h0000_0006, 1'b0);
    wait_frames(200);
    if (starts.size() >= 1) check("a5_start", starts[0], t0 + 1);
    // fill FIFO while disabled, overflow, then 8 back-to-back frames
    bus(1'b1, 4'hC, 32'h0, 4'hF, 0, 1'b0);
    bus(1'b1, 4'h8, 32'h1, 4'hF, 0, 1'b0);
    for (int i = 0; i < 8; i++) txb(fill[i], 1, 1'b1);
    bus(1'b1, 4'h0, {24'h0, fill[8]}, 4'hF, 0, 1'b1);
    bus(1'b0, 4'h4, 0, 4'hF, 32'h0000_0801, 1'b0);
    check("disabled_tx", tx_o, 1);
    starts.delete();
    bus(1'b1, 4'hC, 32'h1, 4'hF, 0, 1'b0);
    t0 = cyc;
    wait_frames(600);
    check("b2b_count", starts.size(), 8);
    if (starts.size() == 8) begin
      check("b2b_first", starts[0], t0 + 1);
      for (int i = 1; i < 8; i++) check("b2b_gap", starts[i] - starts[i-1], 20);
    end
    bus(1'b0, 4'h4, 0, 4'hF, 32'h0000_0002, 1'b0);
    // interrupt falls on push, rises the cycle after the stop bit
    bus(1'b1, 4'h8, 32'h3, 4'hF, 0, 1'b0);
    bus(1'b1, 4'hC, 32'h3, 4'hF, 0, 1'b0);
    check("irq_idle", irq_o, 1);
    txb(8'h3C, 3, 1'b1);
    t0 = cyc;
    check("irq_drop", irq_o, 0);
    n = 0;
    while (!irq_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("irq_rise", cyc, t0 + 41);
    wait_frames(200);
    bus(1'b0, 4'hC, 0, 4'hF, 32'h0000_0003, 1'b0);
    // CLKDIV change mid-frame, STATUS write rejected
    bus(1'b1, 4'hC, 32'h1, 4'hF, 0, 1'b0);
    starts.delete();
    txb(8'h96, 3, 1'b1);
    t0 = cyc;
    txb(8'h0F, 5, 1'b1);
    bus(1'b0, 4'h4, 0, 4'hF, 32'h0000_0104, 1'b0);
    repeat (8) @(negedge clk_i);
    bus(1'b1, 4'h8, 32'h5, 4'hF, 0, 1'b0);
    bus(1'b1, 4'h4, 32'hFFFF_FFFF, 4'hF, 0, 1'b1);
    bus(1'b0, 4'h8, 0, 4'hF, 32'h0000_0005, 1'b0);
    bus(1'b0, 4'hC, 0, 4'hF, 32'h0000_0001, 1'b0);
    bus(1'b0, 4'h4, 0, 4'hF, 32'h0000_0104, 1'b0);
    wait_frames(300);
    check("div_count", starts.size(), 2);
    if (starts.size() == 2) begin
      check("div_first", starts[0], t0 + 1);
      check("div_old_len", starts[1] - starts[0], 40);
    end
    bus(1'b1, 4'h8, 32'h0000_ABCD, 4'b0010, 0, 1'b0);
    bus(1'b0, 4'h8, 0, 4'hF, 32'h0000_AB05, 1'b0);
    // asynchronous reset in the middle of the data bits
    bus(1'b1, 4'h8, 32'h3, 4'hF, 0, 1'b0);
    txb(8'hF0, 3, 1'b0);
    repeat (14) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1 check("mid_rst_tx", tx_o, 1);
    check("mid_rst_irq", irq_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    check("mid_rst_tx_low_none", tx_o, 1);
    bus(1'b0, 4'h4, 0, 4'hF, 32'h0000_0002, 1'b0);
    bus(1'b0, 4'h8, 0, 4'hF, 32'h0000_01B1, 1'b0);
    bus(1'b0, 4'hC, 0, 4'hF, 32'h0000_0001, 1'b0);
    bus(1'b1, 4'h8, 32'h3, 4'hF, 0, 1'b0);
    txb(8'h5A, 3, 1'b1);
    wait_frames(200);
    repeat (3) @(negedge clk_i);
    check("bus_drain", bq.size(), 0);
    check("frame_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
